regfile_dump_reader: RTL

//  Sequential reader that drains the 16x16 register file through one read port.
//  On start it walks register indices 0..NUM_REGS-1, skips those cleared in a mask,
//  and streams each selected register as {index, data} beats over a valid/ready interface.

---
 rtl/regfile_dump_reader_if.sv | 32 +++
 rtl/regfile_dump_reader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader_if.sv
// Beat stream carrying one register per transfer from the dump reader to its consumer.
//   out_valid : beat available (reader -> consumer)
//   out_ready : consumer accepts the beat (consumer -> reader)
//   out_reg   : register index of the beat
//   out_data  : register contents of the beat
//   out_last  : beat is the last selected register of the dump
interface regfile_dump_reader_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_reg;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_reg,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_reg,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Sequential reader that drains the register file through a single read port. On start it
// walks indices 0..NUM_REGS-1, skips registers cleared in the latched mask and streams each
// selected register as an {index, data} beat.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   start    : one-cycle dump request, only honoured while idle
//   reg_mask : register select mask, latched on an accepted start
//   rd_reg   : index driven to the register file read port
//   rd_data  : combinational read data returned for rd_reg
//   dumpOut  : valid/ready beat stream (master side)
//   busy     : high whenever the reader is not idle
//   done     : one-cycle pulse after the final beat or an empty mask
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_REGS-1:0]   reg_mask,
  output logic [ADDR_W-1:0]     rd_reg,
  input  logic [DATA_W-1:0]     rd_data,
  regfile_dump_reader_if.master dumpOut,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]          stateQ, stateD;
  logic [ADDR_W-1:0]   idxQ, idxD;
  logic [NUM_REGS-1:0] maskQ, maskD;
  logic [ADDR_W-1:0]   regQ, regD;
  logic [DATA_W-1:0]   dataQ, dataD;
  logic                lastQ, lastD;

  logic                curSel;
  logic                noneAbove;
  logic [NUM_REGS-1:0] fromIdx;

  assign curSel    = maskQ[idxQ];
  // Mask bits at and above idx, shifted down; bit 0 is idx itself and is excluded.
  assign fromIdx   = maskQ >> idxQ;
  assign noneAbove = (fromIdx & ~NUM_REGS'(1)) == '0;

  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    maskD  = maskQ;
    regD   = regQ;
    dataD  = dataQ;
    lastD  = lastQ;
    case (stateQ)
      IDLE: begin
        if (start) begin
          maskD  = reg_mask;
          idxD   = '0;
          stateD = (reg_mask == '0) ? FIN : SCAN;
        end
      end
      SCAN: begin
        if (curSel) begin
          regD   = idxQ;
          dataD  = rd_data;
          lastD  = noneAbove;
          stateD = SEND;
        end else if (idxQ == LAST_IDX) begin
          stateD = FIN;
        end else begin
          idxD = idxQ + ADDR_W'(1);
        end
      end
      SEND: begin
        if (dumpOut.out_ready) begin
          if (lastQ) begin
            stateD = FIN;
          end else begin
            idxD   = idxQ + ADDR_W'(1);
            stateD = SCAN;
          end
        end
      end
      FIN: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= IDLE;
      idxQ   <= '0;
      maskQ  <= '0;
      regQ   <= '0;
      dataQ  <= '0;
      lastQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      maskQ  <= maskD;
      regQ   <= regD;
      dataQ  <= dataD;
      lastQ  <= lastD;
    end
  end

  assign rd_reg             = (stateQ == SCAN) ? idxQ : '0;
  assign busy               = (stateQ != IDLE);
  assign done               = (stateQ == FIN);
  assign dumpOut.out_valid  = (stateQ == SEND);
  assign dumpOut.out_reg    = regQ;
  assign dumpOut.out_data   = dataQ;
  assign dumpOut.out_last   = lastQ;

endmodule
